// File: rtl/riscv_dm_arb.sv
// Two-port round-robin arbiter in front of a single-ported data memory, with misaligned-access detection.
// Optional per-requester bus locking is built only when RISCV_DMARB_LOCK_EN is defined.
module riscv_dm_arb #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 8
) (
  input  logic                  i_riscv_dmarb_clk,
  input  logic                  i_riscv_dmarb_rst_n,
  input  logic [1:0]            i_riscv_dmarb_req,
  input  logic [1:0]            i_riscv_dmarb_we,
  input  logic [3:0]            i_riscv_dmarb_sel,
  input  logic [2*ADDR_W-1:0]   i_riscv_dmarb_addr,
  input  logic [2*DATA_W-1:0]   i_riscv_dmarb_wdata,
  input  logic [1:0]            i_riscv_dmarb_lock,
  output logic [1:0]            o_riscv_dmarb_gnt,
  output logic [1:0]            o_riscv_dmarb_rvalid,
  output logic [1:0]            o_riscv_dmarb_err,
  output logic [DATA_W-1:0]     o_riscv_dmarb_rdata,
  output logic                  o_riscv_dmarb_dm_wen,
  output logic [1:0]            o_riscv_dmarb_dm_sel,
  output logic [ADDR_W-1:0]     o_riscv_dmarb_dm_addr,
  output logic [DATA_W-1:0]     o_riscv_dmarb_dm_wdata,
  input  logic [DATA_W-1:0]     i_riscv_dmarb_dm_rdata
);

  logic [ADDR_W-1:0] addr0, addr1;
  logic [1:0]        mis, gnt, arb_gnt;
  logic              last_gnt, last_next;

  assign addr0 = i_riscv_dmarb_addr[ADDR_W-1:0];
  assign addr1 = i_riscv_dmarb_addr[2*ADDR_W-1:ADDR_W];

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'b01:   return a[0];
      2'b10:   return |a[1:0];
      2'b11:   return |a;
      default: return 1'b0;
    endcase
  endfunction

  assign mis = {misaligned(i_riscv_dmarb_sel[3:2], addr1[2:0]),
                misaligned(i_riscv_dmarb_sel[1:0], addr0[2:0])};

  // last_gnt == 1 means p1 was served last, so p0 wins a tie.
  always_comb begin
    arb_gnt = 2'b00;
    case (i_riscv_dmarb_req)
      2'b01:   arb_gnt = 2'b01;
      2'b10:   arb_gnt = 2'b10;
      2'b11:   arb_gnt = last_gnt ? 2'b01 : 2'b10;
      default: arb_gnt = 2'b00;
    endcase
  end

`ifdef RISCV_DMARB_LOCK_EN
  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge i_riscv_dmarb_clk or negedge i_riscv_dmarb_rst_n) begin
    if (!i_riscv_dmarb_rst_n) begin
      state <= ARB;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The locking ARB grant counts as the first held cycle, hence the counter starts at 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gnt        = 2'b00;
    last_next  = last_gnt;
    case (state)
      ARB: begin
        gnt = arb_gnt;
        if (gnt[0] && i_riscv_dmarb_lock[0] && !mis[0]) begin
          state_next = LOCK0;
          cnt_next   = CNT_W'(1);
        end else if (gnt[1] && i_riscv_dmarb_lock[1] && !mis[1]) begin
          state_next = LOCK1;
          cnt_next   = CNT_W'(1);
        end
      end
      LOCK0: begin
        gnt = {1'b0, i_riscv_dmarb_req[0]};
        if (cnt == CNT_LAST) begin
          state_next = ARB;
          cnt_next   = '0;
          last_next  = 1'b0;
        end else if (gnt[0] && !i_riscv_dmarb_lock[0]) begin
          state_next = ARB;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      LOCK1: begin
        gnt = {i_riscv_dmarb_req[1], 1'b0};
        if (cnt == CNT_LAST) begin
          state_next = ARB;
          cnt_next   = '0;
          last_next  = 1'b1;
        end else if (gnt[1] && !i_riscv_dmarb_lock[1]) begin
          state_next = ARB;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = ARB;
    endcase
    if (gnt[0]) last_next = 1'b0;
    else if (gnt[1]) last_next = 1'b1;
    if (!i_riscv_dmarb_rst_n) gnt = 2'b00;
  end
`else
  logic unused_lock;
  assign unused_lock = ^i_riscv_dmarb_lock;

  always_comb begin
    gnt       = i_riscv_dmarb_rst_n ? arb_gnt : 2'b00;
    last_next = last_gnt;
    if (gnt[0]) last_next = 1'b0;
    else if (gnt[1]) last_next = 1'b1;
  end
`endif

  assign o_riscv_dmarb_gnt = gnt;

  // Misaligned accesses still reach the memory port but can never write.
  always_comb begin
    o_riscv_dmarb_dm_wen   = 1'b0;
    o_riscv_dmarb_dm_sel   = 2'b00;
    o_riscv_dmarb_dm_addr  = '0;
    o_riscv_dmarb_dm_wdata = '0;
    if (gnt[0]) begin
      o_riscv_dmarb_dm_wen   = i_riscv_dmarb_we[0] & ~mis[0];
      o_riscv_dmarb_dm_sel   = i_riscv_dmarb_sel[1:0];
      o_riscv_dmarb_dm_addr  = addr0;
      o_riscv_dmarb_dm_wdata = i_riscv_dmarb_wdata[DATA_W-1:0];
    end else if (gnt[1]) begin
      o_riscv_dmarb_dm_wen   = i_riscv_dmarb_we[1] & ~mis[1];
      o_riscv_dmarb_dm_sel   = i_riscv_dmarb_sel[3:2];
      o_riscv_dmarb_dm_addr  = addr1;
      o_riscv_dmarb_dm_wdata = i_riscv_dmarb_wdata[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge i_riscv_dmarb_clk or negedge i_riscv_dmarb_rst_n) begin
    if (!i_riscv_dmarb_rst_n) begin
      o_riscv_dmarb_rvalid <= 2'b00;
      o_riscv_dmarb_err    <= 2'b00;
      o_riscv_dmarb_rdata  <= '0;
      last_gnt             <= 1'b1;
    end else begin
      o_riscv_dmarb_rvalid <= gnt;
      o_riscv_dmarb_err    <= gnt & mis;
      last_gnt             <= last_next;
      if (|gnt) o_riscv_dmarb_rdata <= (|(gnt & mis)) ? '0 : i_riscv_dmarb_dm_rdata;
    end
  end

endmodule

// File: tb/tb_riscv_dm_arb.sv
// Directed bench for riscv_dm_arb with a byte-addressed memory model on the memory port.
// Lock behaviour is exercised according to whether RISCV_DMARB_LOCK_EN is defined.
module tb_riscv_dm_arb;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req, we, lock;
  logic [3:0]    sel;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]    gnt, rvalid, err;
  logic [DW-1:0] rdata;
  logic          dm_wen;
  logic [1:0]    dm_sel;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_clear;
  logic [7:0]    mem [0:255];

  int checks = 0;
  int errors = 0;

  riscv_dm_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(8)) dut (
    .i_riscv_dmarb_clk      (clk),
    .i_riscv_dmarb_rst_n    (rst_n),
    .i_riscv_dmarb_req      (req),
    .i_riscv_dmarb_we       (we),
    .i_riscv_dmarb_sel      (sel),
    .i_riscv_dmarb_addr     (addr),
    .i_riscv_dmarb_wdata    (wdata),
    .i_riscv_dmarb_lock     (lock),
    .o_riscv_dmarb_gnt      (gnt),
    .o_riscv_dmarb_rvalid   (rvalid),
    .o_riscv_dmarb_err      (err),
    .o_riscv_dmarb_rdata    (rdata),
    .o_riscv_dmarb_dm_wen   (dm_wen),
    .o_riscv_dmarb_dm_sel   (dm_sel),
    .o_riscv_dmarb_dm_addr  (dm_addr),
    .o_riscv_dmarb_dm_wdata (dm_wdata),
    .i_riscv_dmarb_dm_rdata (dm_rdata)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory: writes the 1<<sel low bytes, reads 8 bytes from the address.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (dm_wen) begin
      for (int i = 0; i < 8; i++)
        if (i < (1 << dm_sel)) mem[dm_addr[7:0] + 8'(i)] <= dm_wdata[8*i +: 8];
    end
  end

  always_comb begin
    dm_rdata = '0;
    for (int i = 0; i < 8; i++) dm_rdata[8*i +: 8] = mem[dm_addr[7:0] + 8'(i)];
  end

  typedef struct {
    bit          do_reset;
    logic [1:0]  req, we, lock;
    logic [3:0]  sel;
    logic [63:0] a0, a1, d0, d1;
    logic [1:0]  exp_gnt;
    logic        exp_wen;
    logic [63:0] exp_addr;
    logic [1:0]  exp_rvalid, exp_err;
    bit          chk_rdata;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, logic [1:0] rq, logic [1:0] w, logic [3:0] s,
                              logic [63:0] a0, logic [63:0] a1, logic [63:0] d0, logic [63:0] d1,
                              logic [1:0] eg, logic ew, logic [63:0] ea, logic [1:0] erv,
                              logic [1:0] ee, bit cr, logic [63:0] erd);
    vec_t v;
    v.do_reset = r;   v.req = rq;   v.we = w;   v.lock = 2'b00; v.sel = s;
    v.a0 = a0;        v.a1 = a1;    v.d0 = d0;  v.d1 = d1;
    v.exp_gnt = eg;   v.exp_wen = ew; v.exp_addr = ea;
    v.exp_rvalid = erv; v.exp_err = ee; v.chk_rdata = cr; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req   = v.req;
    we    = v.we;
    lock  = v.lock;
    sel   = v.sel;
    addr  = {v.a1, v.a0};
    wdata = {v.d1, v.d0};
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    req = 2'b00; we = 2'b00; lock = 2'b00; sel = 4'h0; addr = '0; wdata = '0;
  endtask

  // Leaves rst_n released right at a falling edge so the caller can drive the first cycle.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    setIdle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mem_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_clear = 1'b0;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    setIdle();

    // Single-port traffic, responses and misalignment.
    vecs.push_back(mk(1, 2'b00, 2'b00, 4'h0, 64'h0,  64'h0, 64'h0, 64'h0, 2'b00, 0, 64'h0,  2'b00, 2'b00, 1, 64'h0));
    vecs.push_back(mk(0, 2'b01, 2'b01, 4'h3, 64'h10, 64'h0, 64'h1122334455667788, 64'h0, 2'b01, 1, 64'h10, 2'b00, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 4'h3, 64'h10, 64'h0, 64'h0, 64'h0, 2'b01, 0, 64'h10, 2'b01, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 4'h0, 64'h0,  64'h0, 64'h0, 64'h0, 2'b00, 0, 64'h0,  2'b01, 2'b00, 1, 64'h1122334455667788));
    vecs.push_back(mk(0, 2'b00, 2'b00, 4'h0, 64'h0,  64'h0, 64'h0, 64'h0, 2'b00, 0, 64'h0,  2'b00, 2'b00, 1, 64'h1122334455667788));
    vecs.push_back(mk(0, 2'b01, 2'b01, 4'h2, 64'h4,  64'h0, 64'hCAFEBABE, 64'h0, 2'b01, 1, 64'h4, 2'b00, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b10, 2'b10, 4'h8, 64'h0,  64'h6, 64'h0, 64'hDEADBEEF, 2'b10, 0, 64'h6, 2'b01, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 4'h0, 64'h0,  64'h0, 64'h0, 64'h0, 2'b00, 0, 64'h0,  2'b10, 2'b10, 1, 64'h0));
    vecs.push_back(mk(0, 2'b10, 2'b00, 4'h8, 64'h0,  64'h4, 64'h0, 64'h0, 2'b10, 0, 64'h4,  2'b00, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 4'h0, 64'h0,  64'h0, 64'h0, 64'h0, 2'b00, 0, 64'h0,  2'b10, 2'b00, 1, 64'h00000000CAFEBABE));
    vecs.push_back(mk(0, 2'b01, 2'b00, 4'h1, 64'h11, 64'h0, 64'h0, 64'h0, 2'b01, 0, 64'h11, 2'b00, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 4'h3, 64'h14, 64'h0, 64'h0, 64'h0, 2'b01, 0, 64'h14, 2'b01, 2'b01, 1, 64'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 4'h0, 64'h0,  64'h0, 64'h0, 64'h0, 2'b00, 0, 64'h0,  2'b01, 2'b01, 1, 64'h0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 4'h0, 64'h13, 64'h0, 64'h0, 64'h0, 2'b01, 0, 64'h13, 2'b00, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 4'h0, 64'h0,  64'h0, 64'h0, 64'h0, 2'b00, 0, 64'h0,  2'b01, 2'b00, 1, 64'h0000001122334455));
    // Round robin right after reset: p0 first, then alternating.
    vecs.push_back(mk(1, 2'b11, 2'b00, 4'hF, 64'h10, 64'h8, 64'h0, 64'h0, 2'b01, 0, 64'h10, 2'b00, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 4'hF, 64'h10, 64'h8, 64'h0, 64'h0, 2'b10, 0, 64'h8,  2'b01, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 4'hF, 64'h10, 64'h8, 64'h0, 64'h0, 2'b01, 0, 64'h10, 2'b10, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 4'hF, 64'h10, 64'h8, 64'h0, 64'h0, 2'b10, 0, 64'h8,  2'b01, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 4'hF, 64'h10, 64'h8, 64'h0, 64'h0, 2'b01, 0, 64'h10, 2'b10, 2'b00, 0, 64'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 4'hF, 64'h10, 64'h8, 64'h0, 64'h0, 2'b10, 0, 64'h8,  2'b01, 2'b00, 1, 64'h1122334455667788));
    vecs.push_back(mk(0, 2'b00, 2'b00, 4'h0, 64'h0,  64'h0, 64'h0, 64'h0, 2'b00, 0, 64'h0,  2'b10, 2'b00, 1, 64'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) doReset();
      else @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d gnt", i),    64'(gnt),     64'(vecs[i].exp_gnt));
      checkOutput($sformatf("v%0d dm_wen", i), 64'(dm_wen),  64'(vecs[i].exp_wen));
      checkOutput($sformatf("v%0d dm_addr", i), dm_addr,     vecs[i].exp_addr);
      checkOutput($sformatf("v%0d rvalid", i), 64'(rvalid),  64'(vecs[i].exp_rvalid));
      checkOutput($sformatf("v%0d err", i),    64'(err),     64'(vecs[i].exp_err));
      if (vecs[i].chk_rdata) checkOutput($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
    end

    // Reset in the middle of a write grant cancels the write and clears everything at once.
    @(negedge clk);
    setIdle();
    req = 2'b01; sel = 4'h3; addr = {64'h0, 64'h10};
    #2 checkOutput("rst_pre gnt", 64'(gnt), 64'h1);
    @(negedge clk);
    req = 2'b01; we = 2'b01; sel = 4'h3; addr = {64'h0, 64'h20}; wdata = {64'h0, 64'hAAAAAAAAAAAAAAAA};
    #2;
    checkOutput("rst_wr gnt", 64'(gnt), 64'h1);
    checkOutput("rst_wr wen", 64'(dm_wen), 64'h1);
    checkOutput("rst_wr wdata", dm_wdata, 64'hAAAAAAAAAAAAAAAA);
    checkOutput("rst_wr sel", 64'(dm_sel), 64'h3);
    checkOutput("rst_wr rvalid", 64'(rvalid), 64'h1);
    checkOutput("rst_wr rdata", rdata, 64'h1122334455667788);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async gnt", 64'(gnt), 64'h0);
    checkOutput("rst_async wen", 64'(dm_wen), 64'h0);
    checkOutput("rst_async addr", dm_addr, 64'h0);
    checkOutput("rst_async wdata", dm_wdata, 64'h0);
    checkOutput("rst_async rvalid", 64'(rvalid), 64'h0);
    checkOutput("rst_async rdata", rdata, 64'h0);
    @(negedge clk);
    checkOutput("rst_hold rvalid", 64'(rvalid), 64'h0);
    rst_n = 1'b1;
    setIdle();
    req = 2'b11; sel = 4'hF; addr = {64'h8, 64'h20};
    #2;
    checkOutput("rst_rel gnt", 64'(gnt), 64'h1);
    checkOutput("rst_rel rvalid", 64'(rvalid), 64'h0);
    @(negedge clk);
    setIdle();
    #2;
    checkOutput("rst_rd rvalid", 64'(rvalid), 64'h1);
    checkOutput("rst_rd rdata", rdata, 64'h0);

`ifdef RISCV_DMARB_LOCK_EN
    // p1 locks first, p0 joins; the lock must be broken after exactly eight p1 grants.
    doReset();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      setIdle();
      req = (i == 0) ? 2'b10 : 2'b11; lock = 2'b10; sel = 4'hF; addr = {64'h8, 64'h10};
      #2;
      if (i < 8) checkOutput($sformatf("lock c%0d gnt", i), 64'(gnt), 64'h2);
      else if (i == 8) checkOutput($sformatf("lock c%0d gnt", i), 64'(gnt), 64'h1);
    end
`else
    // Without the lock feature, lock requests are ignored and round robin continues.
    doReset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      setIdle();
      req = 2'b11; lock = 2'b11; sel = 4'hF; addr = {64'h8, 64'h10};
      #2;
      checkOutput($sformatf("nolock c%0d gnt", i), 64'(gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
    end
`endif

    @(negedge clk);
    setIdle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
